// File: rtl/main_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl_pkg
// Shared constants for the main-memory controller slice: line/word geometry
// and the controller FSM state encoding.
// ---------------------------------------------------------------------------
package main_mem_ctrl_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;
    localparam int OFFSET_BITS    = 4;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/main_mem_ctrl_mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// DEPTH_LINES x 128-bit line store. One synchronous write port with a
// per-word (32-bit) enable and one synchronous read port whose registered
// output doubles as the controller's refill line.
//
// Ports
//   clk      : clock, rising edge
//   srst     : synchronous active-high reset; clears only the read register,
//              the array contents are never touched by reset
//   addr     : line index shared by the read and write port
//   wr_en    : write strobe
//   wr_be    : per-word write enable, bit k selects bits [32k+31:32k]
//   wr_data  : write line (only enabled words are stored)
//   rd_en    : read strobe; rd_data loads the addressed line
//   rd_data  : registered read line, held until the next rd_en
// ---------------------------------------------------------------------------
module mem_line_array
    import main_mem_ctrl_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [IDX_W-1:0]          addr,
    input  logic                      wr_en,
    input  logic [WORDS_PER_LINE-1:0] wr_be,
    input  logic [LINE_BITS-1:0]      wr_data,
    input  logic                      rd_en,
    output logic [LINE_BITS-1:0]      rd_data
);

    // Zero image at configuration time; reset never rewrites it.
    logic [LINE_BITS-1:0] mem_array [DEPTH_LINES] = '{default: '0};
    logic [LINE_BITS-1:0] rd_data_q;

    // Write port: the caller is responsible for masking writes during reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                if (wr_be[w]) begin
                    mem_array[addr][w*WORD_BITS +: WORD_BITS] <= wr_data[w*WORD_BITS +: WORD_BITS];
                end
            end
        end
    end

    // Registered read; this register is the visible refill line.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_array[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl
// Single-outstanding main-memory model for a cache: accepts a line read or
// a word write in IDLE, waits LATENCY cycles, then completes with a one-cycle
// mem_ready pulse. Reads refill the whole 128-bit line; writes update one word.
//
// Ports
//   clk, reset       : clock (rising edge), synchronous active-high reset
//   mem_req          : request strobe, only sampled in IDLE
//   mem_write        : 1 = word write, 0 = line read
//   mem_addr         : byte address; line = addr[4 +: log2(DEPTH)], word = addr[3:2]
//   mem_write_data   : write word
//   mem_read_data    : refill line, held until the next read completes
//   mem_ready        : one-cycle completion pulse
//   mem_busy         : high while a request is in flight (BUSY or RESP)
//   read_count/write_count : completed-operation counters
//
// Configuration
//   MAIN_MEM_STATS_EN : when defined, builds the completion counters;
//                       otherwise both counter ports read 0.
// ---------------------------------------------------------------------------
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req,
    input  logic                 mem_write,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_write_data,
    output logic [LINE_BITS-1:0] mem_read_data,
    output logic                 mem_ready,
    output logic                 mem_busy,
    output logic [31:0]          read_count,
    output logic [31:0]          write_count
);

    localparam int         IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       lat_cnt_q, lat_cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       word_q, word_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             complete;

    // Upper address bits alias onto the array and the byte offset is
    // irrelevant for word/line accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:OFFSET_BITS+IDX_W], mem_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        complete  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d   = ST_BUSY;
                    lat_cnt_d = LAT_INIT;
                    write_d   = mem_write;
                    idx_d     = mem_addr[OFFSET_BITS +: IDX_W];
                    word_d    = mem_addr[3:2];
                    wdata_d   = mem_write_data;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_q == 8'd0) begin
                    state_d  = ST_RESP;
                    complete = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
        end
    end

    // Completion on the BUSY->RESP edge drives the array. Reset on that same
    // edge abandons the request, so the write strobe is masked by reset.
    logic                      arr_wr_en;
    logic                      arr_rd_en;
    logic [WORDS_PER_LINE-1:0] arr_wr_be;

    assign arr_wr_en = complete & write_q & ~reset;
    assign arr_rd_en = complete & ~write_q;
    assign arr_wr_be = WORDS_PER_LINE'(1) << word_q;

    mem_line_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_lines (
        .clk     (clk),
        .srst    (reset),
        .addr    (idx_q),
        .wr_en   (arr_wr_en),
        .wr_be   (arr_wr_be),
        .wr_data ({WORDS_PER_LINE{wdata_q}}),
        .rd_en   (arr_rd_en),
        .rd_data (mem_read_data)
    );

    assign mem_ready = (state_q == ST_RESP);
    assign mem_busy  = (state_q != ST_IDLE);

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (complete) begin
            if (write_q) begin
                write_count_d = write_count_q + 32'd1;
            end else begin
                read_count_d = read_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_main_mem_ctrl
// Directed bench for main_mem_ctrl (DEPTH_LINES=1024, LATENCY=4). Inputs are
// driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_main_mem_ctrl;

    localparam int LAT = 4;
`ifdef MAIN_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mem_req = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [31:0]  mem_write_data = '0;
    logic [127:0] mem_read_data;
    logic         mem_ready;
    logic         mem_busy;
    logic [31:0]  read_count;
    logic [31:0]  write_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    main_mem_ctrl #(
        .DEPTH_LINES (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .mem_busy       (mem_busy),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one request and follow it to completion. lat = number of edges
    // after the acceptance edge at which mem_ready was first seen (-1 if
    // never), width = number of sampled cycles with mem_ready high,
    // busy0 = mem_busy right after acceptance. Returns on a falling edge once
    // mem_ready has dropped again (or after a bounded wait).
    task automatic run_op(input logic w, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output int width, output logic busy0);
        int k;
        @(negedge clk);
        mem_req        = 1'b1;
        mem_write      = w;
        mem_addr       = addr;
        mem_write_data = data;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        busy0   = mem_busy;
        lat     = -1;
        width   = 0;
        k       = 0;
        while (k <= 40) begin
            if (mem_ready) begin
                if (lat < 0) lat = k;
                width++;
            end else if (lat >= 0) begin
                break;
            end
            @(negedge clk);
            k++;
        end
        $display("op %s addr=%08h data=%08h lat=%0d width=%0d rd=%032h rc=%0d wc=%0d",
                 w ? "WR" : "RD", addr, data, lat, width, mem_read_data, read_count, write_count);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b1;
        mem_req = 1'b1;          // reset must win over a request
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
        n_cmp++; if (mem_read_data !== 128'd0) begin n_bad++; $display("FAIL reset_rdata got=%032h exp=0", mem_read_data); end
        n_cmp++; if (read_count !== 32'd0) begin n_bad++; $display("FAIL reset_rcount got=%0d exp=0", read_count); end
        n_cmp++; if (write_count !== 32'd0) begin n_bad++; $display("FAIL reset_wcount got=%0d exp=0", write_count); end
        reset   = 1'b0;
        mem_req = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_read_zero();
        int lat, width; logic busy0;
        pulse_reset();
        run_op(1'b0, 32'h0000_0040, 32'h0, lat, width, busy0);
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL rd_busy got=%b exp=1", busy0); end
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (width != 1) begin n_bad++; $display("FAIL rd_ready_width got=%0d exp=1", width); end
        n_cmp++; if (mem_busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle_busy got=%b exp=0", mem_busy); end
        n_cmp++; if (mem_read_data !== 128'd0) begin n_bad++; $display("FAIL rd_data got=%032h exp=0", mem_read_data); end
        n_cmp++; if (read_count !== exp_cnt(1)) begin n_bad++; $display("FAIL rd_rcount got=%0d exp=%0d", read_count, exp_cnt(1)); end
    endtask

    task automatic test_write_read();
        int lat, width; logic busy0;
        logic [127:0] exp_line;
        exp_line = {32'h0, 32'h0, 32'hAABB_CCDD, 32'h0};
        pulse_reset();
        run_op(1'b1, 32'h0000_0044, 32'hAABB_CCDD, lat, width, busy0);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (mem_read_data !== 128'd0) begin n_bad++; $display("FAIL wr_rdata_held got=%032h exp=0", mem_read_data); end
        n_cmp++; if (write_count !== exp_cnt(1)) begin n_bad++; $display("FAIL wr_wcount got=%0d exp=%0d", write_count, exp_cnt(1)); end
        n_cmp++; if (read_count !== 32'd0) begin n_bad++; $display("FAIL wr_rcount got=%0d exp=0", read_count); end
        run_op(1'b0, 32'h0000_0040, 32'h0, lat, width, busy0);
        n_cmp++; if (mem_read_data !== exp_line) begin n_bad++; $display("FAIL wr_rd_line got=%032h exp=%032h", mem_read_data, exp_line); end
        n_cmp++; if (read_count !== exp_cnt(1)) begin n_bad++; $display("FAIL wr_rd_rcount got=%0d exp=%0d", read_count, exp_cnt(1)); end
        n_cmp++; if (write_count !== exp_cnt(1)) begin n_bad++; $display("FAIL wr_rd_wcount got=%0d exp=%0d", write_count, exp_cnt(1)); end
    endtask

    // mem_req held high: accept at E0, ready after E4, RESP->IDLE at E5,
    // re-accept at E6 (first IDLE cycle), second ready after E10.
    task automatic test_back_to_back();
        int n_ready, first_k, second_k;
        logic busy_k5, busy_k6;
        pulse_reset();
        n_ready = 0; first_k = -1; second_k = -1; busy_k5 = 1'bx; busy_k6 = 1'bx;
        @(negedge clk);
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0040;
        @(posedge clk);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                n_ready++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
            if (k == 5) busy_k5 = mem_busy;
            if (k == 6) busy_k6 = mem_busy;
        end
        mem_req = 1'b0;
        for (int k = 0; k < 2*LAT + 4; k++) @(negedge clk);
        $display("b2b ready=%0d first=%0d second=%0d busy5=%b busy6=%b rc=%0d",
                 n_ready, first_k, second_k, busy_k5, busy_k6, read_count);
        n_cmp++; if (n_ready != 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", n_ready); end
        n_cmp++; if (first_k != LAT) begin n_bad++; $display("FAIL b2b_first got=%0d exp=%0d", first_k, LAT); end
        n_cmp++; if (second_k != 2*LAT + 2) begin n_bad++; $display("FAIL b2b_second got=%0d exp=%0d", second_k, 2*LAT+2); end
        n_cmp++; if (busy_k5 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap got=%b exp=0", busy_k5); end
        n_cmp++; if (busy_k6 !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept got=%b exp=1", busy_k6); end
        n_cmp++; if (read_count !== exp_cnt(3)) begin n_bad++; $display("FAIL b2b_rcount got=%0d exp=%0d", read_count, exp_cnt(3)); end
    endtask

    task automatic test_reset_abort();
        int lat, width; logic busy0;
        logic early_ready, late_ready;
        pulse_reset();
        @(negedge clk);
        mem_req        = 1'b1;
        mem_write      = 1'b1;
        mem_addr       = 32'h0000_0040;
        mem_write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        mem_req     = 1'b0;
        early_ready = mem_ready;
        @(negedge clk);
        early_ready = early_ready | mem_ready;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (mem_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", mem_busy); end
        late_ready = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            late_ready = late_ready | mem_ready;
            @(negedge clk);
        end
        $display("abort early_ready=%b late_ready=%b wc=%0d", early_ready, late_ready, write_count);
        n_cmp++; if (early_ready !== 1'b0) begin n_bad++; $display("FAIL abort_early_ready got=%b exp=0", early_ready); end
        n_cmp++; if (late_ready !== 1'b0) begin n_bad++; $display("FAIL abort_late_ready got=%b exp=0", late_ready); end
        n_cmp++; if (write_count !== 32'd0) begin n_bad++; $display("FAIL abort_wcount got=%0d exp=0", write_count); end
        run_op(1'b0, 32'h0000_0040, 32'h0, lat, width, busy0);
        n_cmp++; if (mem_read_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL abort_word0 got=%08h exp=0", mem_read_data[31:0]); end
        n_cmp++; if (read_count !== exp_cnt(1)) begin n_bad++; $display("FAIL abort_rcount got=%0d exp=%0d", read_count, exp_cnt(1)); end
        n_cmp++; if (write_count !== 32'd0) begin n_bad++; $display("FAIL abort_wcount2 got=%0d exp=0", write_count); end
    endtask

    task automatic test_alias();
        int lat, width; logic busy0;
        pulse_reset();
        run_op(1'b1, 32'h0000_4000, 32'h1234_5678, lat, width, busy0);
        run_op(1'b0, 32'h0000_0003, 32'h0, lat, width, busy0);
        n_cmp++; if (mem_read_data[31:0] !== 32'h1234_5678) begin n_bad++; $display("FAIL alias_word0 got=%08h exp=12345678", mem_read_data[31:0]); end
        n_cmp++; if (mem_read_data[127:32] !== 96'h0) begin n_bad++; $display("FAIL alias_upper got=%024h exp=0", mem_read_data[127:32]); end
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL alias_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (write_count !== exp_cnt(1)) begin n_bad++; $display("FAIL alias_wcount got=%0d exp=%0d", write_count, exp_cnt(1)); end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_back_to_back();
        test_reset_abort();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
